// File: rtl/instruction_fetch_stage.sv
// IF stage of the RV32I pipeline: word PC generation, instruction-memory handshake and the IF/ID register.
// A RUN/DRAIN FSM lets an uncancellable in-flight access finish before the redirect target is requested.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_read_o,
    output logic [31:2] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_busywait_i,
    input  logic        busywait_i,
    input  logic        hazard_i,
    input  logic        flush_i,
    input  logic [31:2] target_pc_i,
    output logic [31:2] instr_if_id_o,
    output logic [31:2] pc_if_id_o
);
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [31:2] NOP_INSTR = 30'h0000_0004;

    state_t      state_q, state_d;
    logic [31:2] pc_q, pc_d;
    logic [31:2] drain_addr_q, drain_addr_d;
    logic [31:2] instr_q, instr_d;
    logic [31:2] pc_if_id_q, pc_if_id_d;
    logic        complete;

    // The two low instruction bits are always 2'b11 for RV32I and carry no information.
    logic unused_rdata_bits;
    assign unused_rdata_bits = ^imem_rdata_i[1:0];

    assign imem_read_o   = !rst_i;
    assign imem_addr_o   = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign complete      = imem_read_o && !imem_busywait_i;
    assign instr_if_id_o = instr_q;
    assign pc_if_id_o    = pc_if_id_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        pc_if_id_d   = pc_if_id_q;

        if (busywait_i) begin
            // Whole pipeline frozen; a pending flush will be presented again.
        end else if (flush_i) begin
            pc_d    = target_pc_i;
            instr_d = NOP_INSTR;
            if (state_q == RUN && !complete) begin
                drain_addr_d = pc_q;
                state_d      = DRAIN;
            end else if (state_q == DRAIN && !complete) begin
                state_d = DRAIN;
            end else begin
                state_d = RUN;
            end
        end else if (hazard_i) begin
            // Completed data is dropped; the same address is re-requested next cycle.
            if (state_q == DRAIN && complete) begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            if (complete) begin
                instr_d    = imem_rdata_i[31:2];
                pc_if_id_d = pc_q;
                pc_d       = pc_q + 30'd1;
            end else begin
                instr_d = NOP_INSTR;
            end
        end else begin
            instr_d = NOP_INSTR;
            if (complete) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC[31:2];
            drain_addr_q <= RESET_PC[31:2];
            instr_q      <= NOP_INSTR;
            pc_if_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            pc_if_id_q   <= pc_if_id_d;
        end
    end
endmodule
